counter_timer_ctrl: RTL and testbench
=====================================

// Module: counter_timer_ctrl
// PURPOSE
//   Sequencer for one loadable N-bit up/down counter, turning it into a programmable
//   timer. Captures a period, loads the counter, runs it, detects terminal count and
//   issues tick/done events in one-shot or periodic mode, with pause and stop.
//   Sits between control logic and the counter datapath; owns all load/enable sequencing.
// PARAMETERS
//   N      8   counter / period width in bits
// PORTS
//   clk          input   1   system clock; all state updates on the rising edge
//   reset_al_in  input   1   synchronous, active-low reset, sampled on rising edge of clk
//   start_in     input   1   start request; sampled only in IDLE or DONE
//   stop_in      input   1   abort; highest priority after reset
//   pause_in     input   1   level; freezes counting while high in RUN
//   period_in    input   N   timer period P in cycles; captured on accepted start
//   mode_in      input   1   0 = one-shot, 1 = periodic; captured on accepted start
//   dir_in       input   1   0 = up, 1 = down; captured on accepted start
//   count_out    output  N   current counter value
//   busy_out     output  1   high in LOAD and RUN
//   tick_out     output  1   one-cycle pulse per completed period
//   done_out     output  1   high in DONE (one-shot finished)
//   err_out      output  1   one-cycle pulse when start is rejected (P == 0)
// BEHAVIOUR
//   Reset (reset_al_in==0 at edge): state IDLE; count_out=0; busy/tick/done/err = 0.
//   Registered outputs only; tick_out and err_out are 1-cycle pulses.
//   States: IDLE, LOAD, RUN, DONE.
//   IDLE: start_in & P!=0 -> capture P/mode/dir, go LOAD. start_in & P==0 -> err_out
//     pulses next cycle, stay IDLE. start_in ignored in LOAD/RUN.
//   LOAD (1 cycle): count_out <= 0 (up) or P-1 (down); go RUN.
//   RUN: pause_in=0 -> count +1 (up) / -1 (down) per cycle; pause_in=1 -> hold.
//     Terminal value: P-1 (up) or 0 (down). At an edge in RUN with count at terminal
//     and pause_in=0: tick_out=1 next cycle; periodic -> reload initial value, stay RUN
//     (exactly P cycles between ticks); one-shot -> count holds terminal, go DONE.
//   DONE: done_out=1, busy_out=0; start_in (P!=0) -> LOAD with new capture;
//     stop_in -> IDLE, count_out cleared to 0.
//   stop_in in LOAD/RUN -> IDLE next edge, count holds, no tick even at terminal.
//   Priority: reset > stop > pause > terminal event > count.
//   P==1: counter stays at initial value; periodic ticks every cycle.
//   Arithmetic is modulo 2^N; terminal detection prevents any wrap in normal use.
//   Latency: start at edge E0 -> LOAD; E1 count=initial, RUN; E2 first count step.
// STRUCTURE
//   Package counter_ctrl_pkg: state encoding localparams (IDLE/LOAD/RUN/DONE),
//     MODE_ONESHOT/MODE_PERIODIC, DIR_UP/DIR_DOWN.
//   Sub-module counter_load_updn: N-bit counter with clk, reset_al_in, load_in, d_in,
//     en_in, dir_in, count_out; controller drives load/en/dir/d_in only.
//   Top: FSM, capture registers, terminal compare, output registers.
// TESTING
//   1 Periodic up, P=5: start -> count 0,1,2,3,4,0..; tick_out every 5 cycles, busy_out=1.
//   2 One-shot down, P=3: count 2,1,0; tick_out once; done_out=1, count holds 0, busy=0.
//   3 Pause: up P=4, pause_in high 2 cycles at count 1 -> count holds 1, tick 2 cycles late.
//   4 stop_in asserted on terminal cycle (count=P-1, up) -> IDLE, no tick, count holds.
//   5 start with P=0 -> err_out 1-cycle pulse, stays IDLE; start while busy ignored.
//   6 reset_al_in low mid-RUN (count=3) -> next edge count=0, all outputs 0, IDLE.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter timer controller.
// Holds state codes, mode and direction values.
package counter_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_load_updn.sv
// Loadable N-bit up/down counter.
// Ports: clk, reset_al_in (sync, active low), load_in/d_in, en_in, dir_in, count_out.
module counter_load_updn #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         load_in,
  input  logic [N-1:0] d_in,
  input  logic         en_in,
  input  logic         dir_in,
  output logic [N-1:0] count_out
);

  always_ff @(posedge clk) begin
    if (!reset_al_in) begin
      count_out <= '0;
    end else if (load_in) begin
      count_out <= d_in;
    end else if (en_in) begin
      if (dir_in)
        count_out <= count_out - N'(1);
      else
        count_out <= count_out + N'(1);
    end
  end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Programmable timer sequencer around a loadable up/down counter.
// Ports: clk, reset_al_in, start/stop/pause, period/mode/dir in;
//   count, busy, tick, done, err out (all registered).
module counter_timer_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         start_in,
  input  logic         stop_in,
  input  logic         pause_in,
  input  logic [N-1:0] period_in,
  input  logic         mode_in,
  input  logic         dir_in,
  output logic [N-1:0] count_out,
  output logic         busy_out,
  output logic         tick_out,
  output logic         done_out,
  output logic         err_out
);

  state_t state;
  state_t nxt;

  logic [N-1:0] per_q;
  logic         mode_q;
  logic         dir_q;

  logic [N-1:0] init_val;
  logic [N-1:0] term_val;
  logic         at_term;
  logic         start_ok;
  logic         start_bad;

  logic         ld;
  logic         en;
  logic [N-1:0] d;
  logic         cap;
  logic         tick_d;
  logic         err_d;

  logic         busy_q;
  logic         done_q;
  logic         tick_q;
  logic         err_q;

  assign start_ok  = start_in && (period_in != '0);
  assign start_bad = start_in && (period_in == '0);

  // Up counts 0..P-1, down counts P-1..0.
  assign init_val = (dir_q == DIR_DOWN) ? per_q - N'(1) : '0;
  assign term_val = (dir_q == DIR_DOWN) ? '0 : per_q - N'(1);
  assign at_term  = (count_out == term_val);

  counter_load_updn #(
    .N(N)
  ) u_cnt (
    .clk        (clk),
    .reset_al_in(reset_al_in),
    .load_in    (ld),
    .d_in       (d),
    .en_in      (en),
    .dir_in     (dir_q),
    .count_out  (count_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_al_in)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (!stop_in && start_ok)
          nxt = ST_LOAD;
      end
      (state == ST_LOAD): begin
        nxt = stop_in ? ST_IDLE : ST_RUN;
      end
      (state == ST_RUN): begin
        if (stop_in)
          nxt = ST_IDLE;
        else if (!pause_in && at_term &&
                 mode_q == MODE_ONESHOT)
          nxt = ST_DONE;
      end
      (state == ST_DONE): begin
        if (stop_in)
          nxt = ST_IDLE;
        else if (start_ok)
          nxt = ST_LOAD;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    en     = 1'b0;
    d      = init_val;
    cap    = 1'b0;
    tick_d = 1'b0;
    err_d  = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (!stop_in) begin
          cap   = start_ok;
          err_d = start_bad;
        end
      end
      (state == ST_LOAD): begin
        ld = !stop_in;
      end
      (state == ST_RUN): begin
        if (!stop_in && !pause_in) begin
          if (at_term) begin
            tick_d = 1'b1;
            // One-shot leaves the count parked on terminal.
            ld     = (mode_q == MODE_PERIODIC);
          end else begin
            en = 1'b1;
          end
        end
      end
      (state == ST_DONE): begin
        if (stop_in) begin
          ld = 1'b1;
          d  = '0;
        end else begin
          cap   = start_ok;
          err_d = start_bad;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_al_in) begin
      per_q  <= '0;
      mode_q <= MODE_ONESHOT;
      dir_q  <= DIR_UP;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (cap) begin
        per_q  <= period_in;
        mode_q <= mode_in;
        dir_q  <= dir_in;
      end
      busy_q <= (nxt == ST_LOAD) || (nxt == ST_RUN);
      done_q <= (nxt == ST_DONE);
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign tick_out = tick_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Scoreboard bench for counter_timer_ctrl.
// Reference model tracks period progress as a step index.
module tb_counter_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic [7:0] period;
  logic       mode;
  logic       dir;

  logic [7:0] count;
  logic       busy;
  logic       tick;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  counter_timer_ctrl #(.N(8)) dut (
    .clk        (clk),
    .reset_al_in(rst_n),
    .start_in   (start),
    .stop_in    (stop),
    .pause_in   (pause),
    .period_in  (period),
    .mode_in    (mode),
    .dir_in     (dir),
    .count_out  (count),
    .busy_out   (busy),
    .tick_out   (tick),
    .done_out   (done),
    .err_out    (err)
  );

  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       t;
    logic       d;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Model: phase 0 idle, 1 loading, 2 running, 3 finished.
  int ph = 0;
  int m_p = 0;
  int m_steps = 0;
  int m_shown = 0;
  bit m_per = 0;
  bit m_down = 0;
  bit m_tick = 0;
  bit m_err = 0;

  function automatic int disp(int p, int s, bit dn);
    return dn ? (p - 1 - s) : s;
  endfunction

  task automatic model_start();
    if (int'(period) == 0) begin
      m_err = 1;
    end else begin
      m_p    = int'(period);
      m_per  = mode;
      m_down = dir;
      ph     = 1;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    m_tick = 0;
    m_err  = 0;
    if (!rst_n) begin
      ph      = 0;
      m_shown = 0;
    end else begin
      case (ph)
        0: if (!stop && start) model_start();
        1: begin
          if (stop) ph = 0;
          else begin
            m_steps = 0;
            m_shown = disp(m_p, 0, m_down);
            ph      = 2;
          end
        end
        2: begin
          if (stop) ph = 0;
          else if (!pause) begin
            if (m_steps == m_p - 1) begin
              m_tick = 1;
              if (m_per) m_steps = 0;
              else ph = 3;
            end else begin
              m_steps++;
            end
            m_shown = disp(m_p, m_steps, m_down);
          end
        end
        default: begin
          if (stop) begin
            ph      = 0;
            m_shown = 0;
          end else if (start) begin
            model_start();
          end
        end
      endcase
    end
    e.c = m_shown[7:0];
    e.b = (ph == 1) || (ph == 2);
    e.t = m_tick;
    e.d = (ph == 3);
    e.e = m_err;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {count, busy, tick, done, err};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got cnt=%0d busy=%b tick=%b done=%b err=%b exp cnt=%0d busy=%b tick=%b done=%b err=%b",
                 $time, g.c, g.b, g.t, g.d, g.e, e.c, e.b, e.t, e.d, e.e);
      end
    end
  end

  task automatic drive(input bit s, input bit st, input bit pa,
                       input int p, input bit md, input bit dr);
    start  = s;
    stop   = st;
    pause  = pa;
    period = p[7:0];
    mode   = md;
    dir    = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, int'(period), mode, dir);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    period = 8'd0;
    mode   = 1'b0;
    dir    = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    drive(1, 0, 0, 5, 1, 0);
    idle(14);
    drive(0, 1, 0, 5, 1, 0);
    idle(2);

    drive(1, 0, 0, 3, 0, 1);
    idle(7);
    drive(0, 1, 0, 3, 0, 1);
    idle(2);

    drive(1, 0, 0, 4, 1, 0);
    idle(2);
    drive(0, 0, 1, 4, 1, 0);
    drive(0, 0, 1, 4, 1, 0);
    idle(8);
    drive(0, 1, 0, 4, 1, 0);
    idle(2);

    drive(1, 0, 0, 4, 0, 0);
    idle(4);
    drive(0, 1, 0, 4, 0, 0);
    idle(3);

    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 6, 1, 0);
    idle(1);
    drive(1, 0, 0, 2, 0, 1);
    idle(3);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 0, 0);
    idle(2);

    drive(1, 0, 0, 8, 1, 0);
    idle(4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(3);

    drive(1, 0, 0, 1, 1, 1);
    idle(4);
    drive(0, 1, 0, 1, 1, 1);
    idle(1);
    drive(1, 0, 0, 255, 0, 1);
    idle(3);
    drive(0, 1, 0, 255, 0, 1);
    idle(1);
    drive(1, 0, 0, 2, 0, 0);
    idle(4);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 3, 1, 1);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 9)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
    end

    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0, 0);
    idle(3);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
